// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle controller: states, opcodes,
// instruction classes and the Moore strobe decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_ADDR,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_MEM_ADDR,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_RETIRE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ALU    = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_HALT
    } iclass_t;

    typedef struct packed {
        logic mar_en;
        logic pc_fetch;
        logic w_en;
        logic mdr_en;
        logic st_en;
        logic wr;
        logic rd;
        logic busy;
        logic halted;
    } moore_t;

    // Strobes that depend only on the state being entered.
    function automatic moore_t moore_out(state_t s, iclass_t c);
        moore_t m;
        m = '0;
        m.busy = (s != S_IDLE) && (s != S_HALT);
        case (s)
            S_FETCH_ADDR: begin
                m.mar_en   = 1'b1;
                m.pc_fetch = 1'b1;
            end
            S_FETCH_WAIT: m.rd = 1'b1;
            S_EXEC:       m.w_en = (c == C_ALU);
            S_MEM_ADDR: begin
                m.mar_en = 1'b1;
                m.mdr_en = (c == C_STORE);
            end
            S_MEM_WAIT: begin
                if (c == C_STORE) begin
                    m.wr    = 1'b1;
                    m.st_en = 1'b1;
                end else begin
                    m.rd = 1'b1;
                end
            end
            S_WRITEBACK:  m.w_en = 1'b1;
            S_HALT:       m.halted = 1'b1;
            default:      ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state counter; expired flags the TIMEOUT-th idle wait cycle.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (count) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = count && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer.
// Define MEM_TIMEOUT_EN to enable the hung-bus timeout (bus_err + HALT).
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_fetch,
    input  logic             mem_ready,
    input  logic [OPW-1:0]   ir_opcode,
    input  logic             branch_taken,
    output logic             mar_en,
    output logic             pc_fetch,
    output logic             pc_en,
    output logic             w_en,
    output logic             ir_en,
    output logic             ld_en,
    output logic             st_en,
    output logic             mdr_en,
    output logic             wr,
    output logic             rd,
    output logic             busy,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    if (OPW < 4) begin : g_bad_opw
        $error("OPW must be at least 4");
    end
    if (TIMEOUT < 1 || WIDTH < 1) begin : g_bad_param
        $error("TIMEOUT and WIDTH must be at least 1");
    end

    state_t           r_state;
    state_t           w_nxt;
    iclass_t          r_class;
    iclass_t          w_cls_dec;
    iclass_t          w_cls;
    moore_t           r_moore;
    logic [CNT_W-1:0] r_count;
    logic             w_expired;
    logic             w_in_wait;
    logic             w_fw_done;
    logic             w_ld_done;

    always_comb begin
        w_cls_dec = C_NOP;
        unique case (1'b1)
            (ir_opcode == OPW'(OP_ALU)):    w_cls_dec = C_ALU;
            (ir_opcode == OPW'(OP_LOAD)):   w_cls_dec = C_LOAD;
            (ir_opcode == OPW'(OP_STORE)):  w_cls_dec = C_STORE;
            (ir_opcode == OPW'(OP_BRANCH)): w_cls_dec = C_BRANCH;
            (ir_opcode == OPW'(OP_HALT)):   w_cls_dec = C_HALT;
            default:                        w_cls_dec = C_NOP;
        endcase
    end

    // Class is captured once in DECODE; later opcode changes are ignored.
    assign w_cls = (r_state == S_DECODE) ? w_cls_dec : r_class;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:       if (go_fetch) w_nxt = S_FETCH_ADDR;
            S_FETCH_ADDR: w_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (mem_ready)      w_nxt = S_DECODE;
                else if (w_expired) w_nxt = S_HALT;
            end
            S_DECODE: begin
                case (w_cls_dec)
                    C_ALU, C_BRANCH: w_nxt = S_EXEC;
                    C_LOAD, C_STORE: w_nxt = S_MEM_ADDR;
                    C_HALT:          w_nxt = S_HALT;
                    default:         w_nxt = S_RETIRE;
                endcase
            end
            S_EXEC:       w_nxt = S_RETIRE;
            S_MEM_ADDR:   w_nxt = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem_ready)
                    w_nxt = (r_class == C_STORE) ? S_RETIRE : S_WRITEBACK;
                else if (w_expired)
                    w_nxt = S_HALT;
            end
            S_WRITEBACK:  w_nxt = S_RETIRE;
            S_RETIRE:     w_nxt = go_fetch ? S_FETCH_ADDR : S_IDLE;
            S_HALT:       w_nxt = S_HALT;
            default:      w_nxt = S_IDLE;
        endcase
    end

    assign w_in_wait = (r_state == S_FETCH_WAIT) || (r_state == S_MEM_WAIT);

`ifdef MEM_TIMEOUT_EN
    logic r_bus_err;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!w_in_wait),
        .count  (w_in_wait && !mem_ready),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_expired) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_expired = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_class <= C_NOP;
            r_moore <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nxt;
            r_class <= w_cls;
            r_moore <= moore_out(w_nxt, w_cls);
            if (r_state == S_RETIRE) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Handshake strobes follow mem_ready/branch_taken in the same cycle.
    assign w_fw_done = (r_state == S_FETCH_WAIT) && mem_ready;
    assign w_ld_done = (r_state == S_MEM_WAIT) && (r_class == C_LOAD)
                       && mem_ready;

    assign mar_en      = r_moore.mar_en;
    assign pc_fetch    = r_moore.pc_fetch;
    assign pc_en       = w_fw_done
                         || ((r_state == S_EXEC) && (r_class == C_BRANCH)
                             && branch_taken);
    assign w_en        = r_moore.w_en;
    assign ir_en       = w_fw_done;
    assign ld_en       = w_ld_done;
    assign st_en       = r_moore.st_en;
    assign mdr_en      = r_moore.mdr_en || w_ld_done;
    assign wr          = r_moore.wr;
    assign rd          = r_moore.rd;
    assign busy        = r_moore.busy;
    assign halted      = r_moore.halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction
// cycle-trace model built from the instruction timing rules.
module tb_multicycle_controller;

    localparam logic [12:0] B_MAR  = 13'h1000;
    localparam logic [12:0] B_PCF  = 13'h0800;
    localparam logic [12:0] B_PCE  = 13'h0400;
    localparam logic [12:0] B_WEN  = 13'h0200;
    localparam logic [12:0] B_IR   = 13'h0100;
    localparam logic [12:0] B_LD   = 13'h0080;
    localparam logic [12:0] B_ST   = 13'h0040;
    localparam logic [12:0] B_MDR  = 13'h0020;
    localparam logic [12:0] B_WR   = 13'h0010;
    localparam logic [12:0] B_RD   = 13'h0008;
    localparam logic [12:0] B_BUSY = 13'h0004;
    localparam logic [12:0] B_HLT  = 13'h0002;
    localparam logic [12:0] B_BE   = 13'h0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go_fetch = 1'b0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [3:0]  ir_opcode = 4'd0;
    logic        mar_en, pc_fetch, pc_en, w_en, ir_en, ld_en;
    logic        st_en, mdr_en, wr, rd, busy, halted, bus_err;
    logic [15:0] instr_count;
    logic [12:0] act;

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .go_fetch    (go_fetch),
        .mem_ready   (mem_ready),
        .ir_opcode   (ir_opcode),
        .branch_taken(branch_taken),
        .mar_en      (mar_en),
        .pc_fetch    (pc_fetch),
        .pc_en       (pc_en),
        .w_en        (w_en),
        .ir_en       (ir_en),
        .ld_en       (ld_en),
        .st_en       (st_en),
        .mdr_en      (mdr_en),
        .wr          (wr),
        .rd          (rd),
        .busy        (busy),
        .halted      (halted),
        .bus_err     (bus_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign act = {mar_en, pc_fetch, pc_en, w_en, ir_en, ld_en, st_en,
                  mdr_en, wr, rd, busy, halted, bus_err};

    typedef struct {
        logic [12:0] exp;
        logic        go;
        logic        mr;
        logic        bt;
        logic [3:0]  op;
        int          cnt;
    } cyc_t;

    cyc_t trace[$];
    int   m_cnt;
    int   mw_idx;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic void push(logic [12:0] e, logic go, logic mr,
                                 logic bt, logic [3:0] op);
        cyc_t c;
        c.exp = e;
        c.go  = go;
        c.mr  = mr;
        c.bt  = bt;
        c.op  = op;
        c.cnt = m_cnt;
        trace.push_back(c);
    endfunction

    // Expected cycles of one instruction, from the timing rules per class.
    function automatic void build(logic [3:0] op, int fw, int mw, logic bt,
                                  int idle, logic go_after);
        for (int i = 0; i < idle; i++)
            push(13'h0, (i == idle - 1), rb(), rb(), op);
        push(B_MAR | B_PCF | B_BUSY, rb(), rb(), rb(), op);
        for (int i = 0; i < fw; i++)
            push(B_RD | B_BUSY, rb(), 1'b0, rb(), op);
        push(B_RD | B_IR | B_PCE | B_BUSY, rb(), 1'b1, rb(), op);
        push(B_BUSY, rb(), rb(), rb(), op);
        case (op)
            4'd1: push(B_WEN | B_BUSY, rb(), rb(), rb(), rop());
            4'd4: push(B_BUSY | (bt ? B_PCE : 13'h0), rb(), rb(), bt, rop());
            4'd2: begin
                push(B_MAR | B_BUSY, rb(), rb(), rb(), rop());
                mw_idx = trace.size();
                for (int i = 0; i < mw; i++)
                    push(B_RD | B_BUSY, rb(), 1'b0, rb(), rop());
                push(B_RD | B_MDR | B_LD | B_BUSY, rb(), 1'b1, rb(), rop());
                push(B_WEN | B_BUSY, rb(), rb(), rb(), rop());
            end
            4'd3: begin
                push(B_MAR | B_MDR | B_BUSY, rb(), rb(), rb(), rop());
                for (int i = 0; i < mw; i++)
                    push(B_WR | B_ST | B_BUSY, rb(), 1'b0, rb(), rop());
                push(B_WR | B_ST | B_BUSY, rb(), 1'b1, rb(), rop());
            end
            4'd15: begin
                for (int i = 0; i < 6; i++)
                    push(B_HLT, rb(), rb(), rb(), rop());
                return;
            end
            default: ;
        endcase
        push(B_BUSY, go_after, rb(), rb(), rop());
        m_cnt++;
    endfunction

    task automatic run(input int upto);
        cyc_t c;
        for (int i = 0; i < upto; i++) begin
            c = trace[i];
            @(posedge clk);
            #1;
            go_fetch     = c.go;
            mem_ready    = c.mr;
            branch_taken = c.bt;
            ir_opcode    = c.op;
            @(negedge clk);
            chk($sformatf("strobes@%0d", i), 32'(act), 32'(c.exp));
            chk($sformatf("instr_count@%0d", i), 32'(instr_count), 32'(c.cnt));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        go_fetch  = rb();
        mem_ready = rb();
        ir_opcode = rop();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        go_fetch = 1'b0;
        @(negedge clk);
        chk("reset_strobes", 32'(act), 32'h0);
        chk("reset_count", 32'(instr_count), 32'h0);
        trace.delete();
        m_cnt = 0;
    endtask

    task automatic rand_episode();
        int   n;
        int   idle[12];
        logic [3:0] op;
        bit   hit_halt;
        do_reset();
        n = $urandom_range(3, 10);
        hit_halt = 1'b0;
        for (int i = 0; i <= n; i++)
            idle[i] = (i == 0) ? $urandom_range(1, 3)
                    : (rb() ? 0 : $urandom_range(1, 3));
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) op = rop();
            build(op, $urandom_range(0, 4), $urandom_range(0, 4), rb(),
                  idle[i], (i < n - 1) ? (idle[i + 1] == 0) : 1'b0);
            if (op == 4'd15) begin
                hit_halt = 1'b1;
                break;
            end
        end
        if (!hit_halt) begin
            push(13'h0, 1'b0, rb(), rb(), rop());
            push(13'h0, 1'b0, rb(), rb(), rop());
        end
        run(trace.size());
    endtask

    initial begin
        m_cnt  = 0;
        mw_idx = 0;

        // Zero-wait ALU back to back
        do_reset();
        build(4'd1, 0, 0, 1'b0, 1, 1'b1);
        build(4'd1, 0, 0, 1'b0, 0, 1'b1);
        build(4'd1, 0, 0, 1'b0, 0, 1'b0);
        push(13'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        run(trace.size());

        // LOAD 3 waits, STORE, both branch outcomes
        do_reset();
        build(4'd2, 0, 3, 1'b0, 1, 1'b0);
        build(4'd3, 1, 2, 1'b0, 1, 1'b1);
        build(4'd4, 0, 0, 1'b1, 0, 1'b1);
        build(4'd4, 0, 0, 1'b0, 0, 1'b0);
        push(13'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        run(trace.size());

        // Long fetch wait completes, then HALT
        do_reset();
        build(4'd1, 14, 0, 1'b0, 1, 1'b1);
        build(4'd15, 0, 0, 1'b0, 0, 1'b0);
        run(trace.size());

        // Reset in MEM_WAIT of a LOAD
        do_reset();
        build(4'd1, 0, 0, 1'b0, 1, 1'b1);
        build(4'd1, 0, 0, 1'b0, 0, 1'b1);
        build(4'd2, 0, 5, 1'b0, 0, 1'b0);
        run(mw_idx + 2);
        do_reset();

`ifdef MEM_TIMEOUT_EN
        // Stuck fetch: 15 wait cycles then HALT with bus_err
        do_reset();
        push(13'h0, 1'b1, 1'b0, 1'b0, 4'd1);
        push(B_MAR | B_PCF | B_BUSY, rb(), 1'b0, rb(), 4'd1);
        for (int i = 0; i < 15; i++)
            push(B_RD | B_BUSY, rb(), 1'b0, rb(), 4'd1);
        for (int i = 0; i < 4; i++)
            push(B_HLT | B_BE, rb(), rb(), rb(), rop());
        run(trace.size());
`endif

        repeat (25) rand_episode();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
